// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: region masks, access size codes,
// RAM write-strobe codes, FSM state and grant encodings.
package mem_arbiter_pkg;

  // Region masks. The RAM window is 8 KiB and the IO window is one 32-bit word.
  localparam logic [31:0] RAM_MASK = 32'hFFFF_E000;
  localparam logic [31:0] IO_MASK  = 32'hFFFF_FFFC;

  // Access size codes carried on d_req_size.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // One-hot RAM write strobes.
  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_WAIT = 2'd1,
    RESP     = 2'd2
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_t;

  // Maps an access size to its RAM write strobe; the illegal size gets none.
  function automatic logic [2:0] size_strobe(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_strobe = WE_BYTE;
      SZ_HALF: size_strobe = WE_HALF;
      SZ_WORD: size_strobe = WE_WORD;
      default: size_strobe = WE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_load_extend.sv
// load_extend: combinational load-data extension.
//   data        in  32  right-aligned load data
//   size        in  2   byte / half / word
//   is_unsigned in  1   zero-extend instead of sign-extend
//   ext         out 32  extended result (word loads pass through)
module load_extend
  import mem_arbiter_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext
);

  always_comb begin
    ext = data;
    case (size)
      SZ_BYTE: ext = {{24{data[7]  & ~is_unsigned}}, data[7:0]};
      SZ_HALF: ext = {{16{data[15] & ~is_unsigned}}, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the data RAM, boot ROM and GPIO register between the
// instruction-fetch port (i_*) and the load/store port (d_*). One transaction
// is outstanding at a time; each accepted request gets exactly one registered
// response pulse on its own port, with a fault flag for illegal accesses.
//   clk, reset                 clock, synchronous active-high reset
//   i_req_* / i_rsp_*          fetch request / response
//   d_req_* / d_rsp_*          load/store request / response
//   ram_write_enable           one-hot strobe [0]=word [1]=half [2]=byte
//   ram_addr, ram_data_in      RAM/IO address and store data
//   ram_data_out               registered RAM read data, pre-shifted by addr[1:0]
//   rom_addr, rom_data         combinational ROM port
//   busy                       a transaction is outstanding
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = 32'h1000_0000,
  parameter logic [31:0] IO_BASE   = 32'h2000_0000,
  parameter int          ROM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  output logic        i_rsp_fault,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic        d_req_we,
  input  logic [1:0]  d_req_size,
  input  logic        d_req_unsigned,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_rdata,
  output logic        d_rsp_fault,
  output logic [2:0]  ram_write_enable,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        busy
);

  localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS) << 2;

  state_t      state_reg, state_next;
  grant_t      last_grant_reg;
  grant_t      port_reg;
  logic [31:0] addr_reg, wdata_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;

  logic        i_rsp_valid_reg, i_rsp_fault_reg;
  logic [31:0] i_rsp_data_reg;
  logic        d_rsp_valid_reg, d_rsp_fault_reg;
  logic [31:0] d_rsp_data_reg;

  logic        idle;
  logic        grant_fetch, grant_data, accept;
  logic [31:0] sel_addr;
  logic [1:0]  sel_size;
  logic        sel_we, sel_uns;
  logic        in_rom, in_ram, in_io, misaligned;
  logic        req_fault, ram_load;
  logic [31:0] rom_shifted, imm_data;
  logic [31:0] ext_in, ext_out;
  logic [1:0]  ext_size;
  logic        ext_uns;

  // Round-robin: on a tie the port that did not win last time is granted.
  assign idle        = (state_reg == IDLE);
  assign grant_data  = d_req_valid && (!i_req_valid || last_grant_reg == FETCH);
  assign grant_fetch = i_req_valid && !grant_data;
  assign i_req_ready = idle && grant_fetch && !reset;
  assign d_req_ready = idle && grant_data && !reset;
  assign accept      = i_req_ready || d_req_ready;

  // Fields of the granted request; a fetch is always an unsigned word read.
  assign sel_addr = grant_data ? d_req_addr : i_req_addr;
  assign sel_size = grant_data ? d_req_size : SZ_WORD;
  assign sel_we   = grant_data && d_req_we;
  assign sel_uns  = grant_data ? d_req_unsigned : 1'b1;

  assign in_rom     = (sel_addr < ROM_BYTES);
  assign in_ram     = ((sel_addr & RAM_MASK) == RAM_BASE);
  assign in_io      = ((sel_addr & IO_MASK) == IO_BASE);
  assign misaligned = ((sel_size == SZ_HALF) && sel_addr[0]) ||
                      ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00));

  always_comb begin
    req_fault = 1'b0;
    if (grant_data) begin
      req_fault = (sel_size == 2'd3) || misaligned ||
                  (in_rom && sel_we) ||
                  (in_io && sel_size != SZ_BYTE) ||
                  !(in_rom || in_ram || in_io);
    end else begin
      req_fault = misaligned || !(in_rom || in_ram);
    end
  end

  // Only legal RAM reads take the extra wait cycle for the registered RAM data.
  assign ram_load = in_ram && !sel_we && !req_fault;

  // One extender serves both paths: ROM data in the accept cycle, RAM data
  // in RAM_WAIT using the size captured at accept.
  assign rom_addr    = sel_addr;
  assign rom_shifted = rom_data >> {sel_addr[1:0], 3'b000};
  assign ext_in      = (state_reg == RAM_WAIT) ? ram_data_out : rom_shifted;
  assign ext_size    = (state_reg == RAM_WAIT) ? size_reg : sel_size;
  assign ext_uns     = (state_reg == RAM_WAIT) ? uns_reg : sel_uns;

  load_extend u_load_extend (
    .data        (ext_in),
    .size        (ext_size),
    .is_unsigned (ext_uns),
    .ext         (ext_out)
  );

  // Immediate response data: faults, stores and IO reads all return zero.
  assign imm_data = (!req_fault && !sel_we && in_rom) ? ext_out : 32'h0;

  assign ram_write_enable = (accept && sel_we && !req_fault) ? size_strobe(sel_size) : WE_NONE;
  assign ram_addr         = idle ? sel_addr : addr_reg;
  assign ram_data_in      = idle ? d_req_wdata : wdata_reg;
  assign busy             = !idle;

  assign i_rsp_valid = i_rsp_valid_reg;
  assign i_rsp_data  = i_rsp_data_reg;
  assign i_rsp_fault = i_rsp_fault_reg;
  assign d_rsp_valid = d_rsp_valid_reg;
  assign d_rsp_rdata = d_rsp_data_reg;
  assign d_rsp_fault = d_rsp_fault_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (accept) state_next = ram_load ? RAM_WAIT : RESP;
      RAM_WAIT: state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg  <= FETCH;
      port_reg        <= FETCH;
      addr_reg        <= 32'h0;
      wdata_reg       <= 32'h0;
      size_reg        <= SZ_BYTE;
      uns_reg         <= 1'b0;
      i_rsp_valid_reg <= 1'b0;
      i_rsp_fault_reg <= 1'b0;
      i_rsp_data_reg  <= 32'h0;
      d_rsp_valid_reg <= 1'b0;
      d_rsp_fault_reg <= 1'b0;
      d_rsp_data_reg  <= 32'h0;
    end else begin
      i_rsp_valid_reg <= 1'b0;
      d_rsp_valid_reg <= 1'b0;
      if (accept) begin
        last_grant_reg <= grant_data ? DATA : FETCH;
        port_reg       <= grant_data ? DATA : FETCH;
        addr_reg       <= sel_addr;
        wdata_reg      <= d_req_wdata;
        size_reg       <= sel_size;
        uns_reg        <= sel_uns;
        if (!ram_load) begin
          if (grant_data) begin
            d_rsp_valid_reg <= 1'b1;
            d_rsp_fault_reg <= req_fault;
            d_rsp_data_reg  <= imm_data;
          end else begin
            i_rsp_valid_reg <= 1'b1;
            i_rsp_fault_reg <= req_fault;
            i_rsp_data_reg  <= imm_data;
          end
        end
      end
      if (state_reg == RAM_WAIT) begin
        if (port_reg == DATA) begin
          d_rsp_valid_reg <= 1'b1;
          d_rsp_fault_reg <= 1'b0;
          d_rsp_data_reg  <= ext_out;
        end else begin
          i_rsp_valid_reg <= 1'b1;
          i_rsp_fault_reg <= 1'b0;
          i_rsp_data_reg  <= ext_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cases followed by random traffic
// on both ports, predicted by a byte-level memory model of the address map.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req_valid = 1'b0, i_req_ready;
  logic [31:0] i_req_addr = '0;
  logic        i_rsp_valid, i_rsp_fault;
  logic [31:0] i_rsp_data;
  logic        d_req_valid = 1'b0, d_req_ready;
  logic [31:0] d_req_addr = '0, d_req_wdata = '0;
  logic        d_req_we = 1'b0, d_req_unsigned = 1'b0;
  logic [1:0]  d_req_size = '0;
  logic        d_rsp_valid, d_rsp_fault;
  logic [31:0] d_rsp_rdata;
  logic [2:0]  ram_write_enable;
  logic [31:0] ram_addr, ram_data_in, ram_data_out, rom_addr, rom_data;
  logic        busy;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_fault(i_rsp_fault),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_size(d_req_size), .d_req_unsigned(d_req_unsigned),
    .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata), .d_rsp_fault(d_rsp_fault),
    .ram_write_enable(ram_write_enable), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          port;   // 1 = data port
    logic [31:0] data;
    bit          fault;
    int          cyc;
  } exp_t;

  req_t iq[$], dq[$];
  exp_t sb[$];
  int   checks = 0, errors = 0, cycle = 0, free_cycle = 0;
  bit   ref_last_data = 1'b0, mon_en = 1'b0, rst_cmd = 1'b1;
  logic [31:0] rom [256];
  logic [7:0]  env_mem [8192];
  logic [7:0]  ref_mem [8192];

  // ROM and RAM environment seen by the DUT.
  assign rom_data = (rom_addr < 32'd1024) ? rom[rom_addr[9:2]] : 32'hDEAD_BEEF;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin : ram_env
    int off;
    off = int'(ram_addr - 32'h1000_0000);
    if (ram_addr >= 32'h1000_0000 && ram_addr < 32'h1000_2000) begin
      ram_data_out <= {env_mem[(off & ~3) + 3], env_mem[(off & ~3) + 2],
                       env_mem[(off & ~3) + 1], env_mem[off & ~3]} >> (8 * (off & 3));
      if (ram_write_enable == 3'b100) env_mem[off] <= ram_data_in[7:0];
      if (ram_write_enable == 3'b010) begin
        env_mem[off] <= ram_data_in[7:0]; env_mem[off + 1] <= ram_data_in[15:8];
      end
      if (ram_write_enable == 3'b001) begin
        for (int k = 0; k < 4; k++) env_mem[off + k] <= ram_data_in[8*k +: 8];
      end
    end else begin
      ram_data_out <= 32'h0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model of one access, from the address map and access rules.
  task automatic predict(input bit is_data, input req_t r, output bit fault,
                         output logic [31:0] data, output int lat, output logic [2:0] we);
    bit rom_r, ram_r, io_r;
    int nb, a;
    logic [31:0] v, b;
    rom_r = r.addr < 32'd1024;
    ram_r = r.addr >= 32'h1000_0000 && r.addr < 32'h1000_2000;
    io_r  = r.addr >= 32'h2000_0000 && r.addr < 32'h2000_0004;
    nb = !is_data ? 4 : (r.size == 0) ? 1 : (r.size == 1) ? 2 : 4;
    if (!is_data) fault = (r.addr % 4 != 0) || !(rom_r || ram_r);
    else fault = (r.size == 3) || (r.addr % nb != 0) || (rom_r && r.we) ||
                 (io_r && r.size != 0) || !(rom_r || ram_r || io_r);
    lat  = (!fault && ram_r && !(is_data && r.we)) ? 2 : 1;
    data = 32'h0;
    we   = 3'b000;
    if (!fault && is_data && r.we) begin
      we = (nb == 1) ? 3'b100 : (nb == 2) ? 3'b010 : 3'b001;
      if (ram_r)
        for (int k = 0; k < nb; k++) ref_mem[int'(r.addr - 32'h1000_0000) + k] = r.wdata[8*k +: 8];
    end else if (!fault && !io_r) begin
      v = 32'h0;
      for (int k = 0; k < nb; k++) begin
        a = int'(r.addr) + k;
        if (rom_r) b = (rom[a / 4] >> (8 * (a % 4))) & 32'hFF;
        else       b = {24'h0, ref_mem[int'(r.addr - 32'h1000_0000) + k]};
        v = v | (b << (8 * k));
      end
      if (nb < 4 && !(is_data && r.uns) && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 1);
      data = v;
    end
  endtask

  // One clock cycle of stimulus plus the cycle-level checks of the accept cycle.
  task automatic step();
    req_t ri, rd;
    bit vi, vd, exp_gi, exp_gd, fault;
    logic [31:0] data;
    logic [2:0] we, exp_we;
    int lat;
    @(negedge clk);
    reset = rst_cmd;
    vi = iq.size() > 0;
    vd = dq.size() > 0;
    ri = vi ? iq[0] : '{$urandom, 1'b0, 2'd2, 1'b0, 32'h0};
    rd = vd ? dq[0] : '{$urandom, 1'($urandom), 2'($urandom), 1'($urandom), $urandom};
    i_req_valid = vi; i_req_addr = ri.addr;
    d_req_valid = vd; d_req_addr = rd.addr; d_req_we = rd.we; d_req_size = rd.size;
    d_req_unsigned = rd.uns; d_req_wdata = rd.wdata;
    #1;
    exp_gi = 1'b0; exp_gd = 1'b0;
    if (!reset && cycle >= free_cycle) begin
      exp_gd = vd && (!vi || !ref_last_data);
      exp_gi = vi && !exp_gd;
    end
    check("i_req_ready", i_req_ready, exp_gi);
    check("d_req_ready", d_req_ready, exp_gd);
    check("busy", busy, cycle < free_cycle);
    exp_we = 3'b000;
    if (exp_gd || exp_gi) begin
      predict(exp_gd, exp_gd ? rd : ri, fault, data, lat, we);
      exp_we = we;
      check("ram_addr", ram_addr, exp_gd ? rd.addr : ri.addr);
      if (we != 3'b000) check("ram_data_in", ram_data_in, rd.wdata);
      sb.push_back('{exp_gd, data, fault, cycle + lat});
      if (exp_gd) void'(dq.pop_front()); else void'(iq.pop_front());
      ref_last_data = exp_gd;
      free_cycle = cycle + lat + 1;
    end
    check("ram_write_enable", ram_write_enable, exp_we);
    if (reset) begin
      // Anything not yet delivered is dropped by the reset.
      for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].cyc > cycle) sb.delete(k);
      free_cycle = cycle + 1;
      ref_last_data = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((iq.size() > 0 || dq.size() > 0 || sb.size() > 0 || cycle < free_cycle) && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=pending required=idle");
    end
  endtask

  function automatic req_t dreq(input logic [31:0] a, input bit w, input logic [1:0] s,
                                input bit u, input logic [31:0] wd);
    dreq = '{a, w, s, u, wd};
  endfunction

  function automatic logic [31:0] rand_addr(input int nb);
    logic [31:0] a;
    case ($urandom % 6)
      0, 1:    a = $urandom % 1040;
      2, 3:    a = 32'h1000_0000 + $urandom % 8200;
      4:       a = 32'h2000_0000 + $urandom % 8;
      default: a = $urandom;
    endcase
    if ($urandom % 4 != 0) a = a & ~(32'(nb) - 1);
    return a;
  endfunction

  // Monitor: pops the scoreboard whenever a response pulse appears.
  initial begin : monitor
    exp_t e;
    bit dv;
    wait (mon_en);
    forever begin
      @(negedge clk);
      if (i_rsp_valid || d_rsp_valid) begin
        check("rsp_overlap", i_rsp_valid & d_rsp_valid, 0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected actual=i%b_d%b required=no_response (cycle %0d)",
                   i_rsp_valid, d_rsp_valid, cycle);
        end else begin
          e = sb.pop_front();
          dv = d_rsp_valid;
          check("rsp_port", dv, e.port);
          check("rsp_cycle", cycle, e.cyc);
          check("rsp_data", dv ? d_rsp_rdata : i_rsp_data, e.data);
          check("rsp_fault", dv ? d_rsp_fault : i_rsp_fault, e.fault);
          $display("rsp port=%s data=%h fault=%b cycle=%0d", dv ? "D" : "I",
                   dv ? d_rsp_rdata : i_rsp_data, dv ? d_rsp_fault : i_rsp_fault, cycle);
        end
      end else if (sb.size() > 0 && sb[0].cyc < cycle) begin
        checks++; errors++;
        $display("FAIL rsp_missing actual=none required=port%0d_at_cycle_%0d", sb[0].port, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin : stimulus
    logic [7:0] b;
    int n;
    req_t r;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[4] = 32'h0050_0093;
    for (int i = 0; i < 8192; i++) begin
      b = 8'($urandom);
      env_mem[i] = b;
      ref_mem[i] = b;
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    // Both ports valid while still in reset, then released together.
    iq.push_back('{32'h10, 1'b0, 2'd2, 1'b0, 32'h0});
    dq.push_back(dreq(32'h1000_0005, 1, 0, 0, 32'h0000_00AB));
    dq.push_back(dreq(32'h1000_0005, 0, 0, 0, 32'h0));
    dq.push_back(dreq(32'h1000_0005, 0, 0, 1, 32'h0));
    rst_cmd = 1'b1;
    step(); step();
    rst_cmd = 1'b0;
    drain();

    // Faults, IO and region boundaries.
    dq.push_back(dreq(32'h1000_0003, 0, 1, 0, 32'h0));
    dq.push_back(dreq(32'h0000_0040, 1, 2, 0, 32'h1234_5678));
    dq.push_back(dreq(32'h2000_0000, 1, 0, 0, 32'h0000_005A));
    dq.push_back(dreq(32'h2000_0000, 1, 1, 0, 32'h0000_1234));
    dq.push_back(dreq(32'h2000_0001, 0, 0, 0, 32'h0));
    dq.push_back(dreq(32'h1000_1FFC, 1, 2, 0, 32'h8765_4321));
    dq.push_back(dreq(32'h1000_1FFE, 0, 1, 0, 32'h0));
    dq.push_back(dreq(32'h1000_2000, 0, 2, 0, 32'h0));
    dq.push_back(dreq(32'h0000_0012, 0, 1, 0, 32'h0));
    dq.push_back(dreq(32'h1000_0100, 0, 3, 0, 32'h0));
    iq.push_back('{32'h3FC, 1'b0, 2'd2, 1'b0, 32'h0});
    iq.push_back('{32'h400, 1'b0, 2'd2, 1'b0, 32'h0});
    iq.push_back('{32'h002, 1'b0, 2'd2, 1'b0, 32'h0});
    iq.push_back('{32'h1000_1FFC, 1'b0, 2'd2, 1'b0, 32'h0});
    drain();

    // Reset during RAM_WAIT of a load drops its response.
    dq.push_back(dreq(32'h1000_0004, 0, 2, 0, 32'h0));
    n = 0;
    while (dq.size() > 0 && n < 50) begin step(); n++; end
    rst_cmd = 1'b1;
    step();
    rst_cmd = 1'b0;
    dq.push_back(dreq(32'h1000_0004, 0, 2, 0, 32'h0));
    drain();

    // Random traffic on both ports.
    for (int c = 0; c < 3000; c++) begin
      if (iq.size() == 0 && $urandom % 3 == 0)
        iq.push_back('{rand_addr(4), 1'b0, 2'd2, 1'b0, 32'h0});
      if (dq.size() == 0 && $urandom % 3 == 0) begin
        n = $urandom % 8;
        r.size  = (n < 7) ? 2'(n % 3) : 2'd3;
        r.we    = 1'($urandom);
        r.uns   = 1'($urandom);
        r.wdata = $urandom;
        r.addr  = rand_addr((r.size == 0) ? 1 : (r.size == 1) ? 2 : 4);
        dq.push_back(r);
      end
      step();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
